// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline stage: two-entry elastic buffer (main + skid) with a registered in_ready,
// synchronous flush, a forwarding tap off the head entry and a saturating stall counter.
module ex_mem_skid_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned F3_W   = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mux_d_mem,
    input  logic              in_write_reg_en,
    input  logic              in_d_mem_r,
    input  logic              in_d_mem_w,
    input  logic [REG_AW-1:0] in_write_address,
    input  logic [F3_W-1:0]   in_fun_3,
    input  logic [XLEN-1:0]   in_data_2,
    input  logic [XLEN-1:0]   in_alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mux_d_mem,
    output logic              out_write_reg_en,
    output logic              out_d_mem_r,
    output logic              out_d_mem_w,
    output logic [REG_AW-1:0] out_write_address,
    output logic [F3_W-1:0]   out_fun_3,
    output logic [XLEN-1:0]   out_data_2,
    output logic [XLEN-1:0]   out_alu_result,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_address,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              mux_d_mem;
        logic              write_reg_en;
        logic [REG_AW-1:0] write_address;
        logic              d_mem_r;
        logic              d_mem_w;
        logic [F3_W-1:0]   fun_3;
        logic [XLEN-1:0]   data_2;
        logic [XLEN-1:0]   alu_result;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t   state_q, state_d;
    payload_t main_q, skid_q, in_payload;
    logic     in_fire, out_fire;
    logic     load_main_in, load_main_skid, load_skid;

    assign in_payload = '{
        mux_d_mem:     in_mux_d_mem,
        write_reg_en:  in_write_reg_en,
        write_address: in_write_address,
        d_mem_r:       in_d_mem_r,
        d_mem_w:       in_d_mem_w,
        fun_3:         in_fun_3,
        data_2:        in_data_2,
        alu_result:    in_alu_result
    };

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next state and register load enables; flush overrides everything and loads nothing.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_payload;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign out_mux_d_mem     = main_q.mux_d_mem;
    assign out_write_reg_en  = main_q.write_reg_en & out_valid;
    assign out_d_mem_r       = main_q.d_mem_r & out_valid;
    assign out_d_mem_w       = main_q.d_mem_w & out_valid;
    assign out_write_address = main_q.write_address;
    assign out_fun_3         = main_q.fun_3;
    assign out_data_2        = main_q.data_2;
    assign out_alu_result    = main_q.alu_result;

    assign fwd_valid   = out_valid & main_q.write_reg_en & ~main_q.mux_d_mem
                       & (main_q.write_address != '0);
    assign fwd_address = main_q.write_address;
    assign fwd_data    = main_q.alu_result;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed test-plan steps plus random traffic checked against a
// two-deep queue model; a second instance with a 4-bit counter exercises saturation.
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic        mux;
        logic        wre;
        logic [4:0]  wa;
        logic        r;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] d2;
        logic [31:0] alu;
    } pl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    pl_t  drv = '0;

    logic        in_ready, out_valid;
    logic        out_mux_d_mem, out_write_reg_en, out_d_mem_r, out_d_mem_w;
    logic [4:0]  out_write_address, fwd_address;
    logic [2:0]  out_fun_3;
    logic [31:0] out_data_2, out_alu_result, fwd_data;
    logic        fwd_valid;
    logic [15:0] stall_count;

    // Small-counter instance signals
    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic        s_in_ready, s_out_valid, s_mux, s_wre, s_r, s_w, s_fwd_valid;
    logic [4:0]  s_wa, s_fwd_address;
    logic [2:0]  s_f3;
    logic [31:0] s_d2, s_alu, s_fwd_data;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    pl_t         mq[$];
    pl_t         last_head = '0;
    int unsigned mcnt = 0;
    logic [31:0] got[$];

    always #5 clk = ~clk;

    ex_mem_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mux_d_mem(drv.mux), .in_write_reg_en(drv.wre), .in_d_mem_r(drv.r), .in_d_mem_w(drv.w),
        .in_write_address(drv.wa), .in_fun_3(drv.f3), .in_data_2(drv.d2), .in_alu_result(drv.alu),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mux_d_mem(out_mux_d_mem), .out_write_reg_en(out_write_reg_en),
        .out_d_mem_r(out_d_mem_r), .out_d_mem_w(out_d_mem_w),
        .out_write_address(out_write_address), .out_fun_3(out_fun_3),
        .out_data_2(out_data_2), .out_alu_result(out_alu_result),
        .fwd_valid(fwd_valid), .fwd_address(fwd_address), .fwd_data(fwd_data),
        .stall_count(stall_count)
    );

    ex_mem_skid_reg #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_mux_d_mem(1'b0), .in_write_reg_en(1'b1), .in_d_mem_r(1'b0), .in_d_mem_w(1'b0),
        .in_write_address(5'd1), .in_fun_3(3'd0), .in_data_2(32'd0), .in_alu_result(32'h55),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_mux_d_mem(s_mux), .out_write_reg_en(s_wre), .out_d_mem_r(s_r), .out_d_mem_w(s_w),
        .out_write_address(s_wa), .out_fun_3(s_f3), .out_data_2(s_d2), .out_alu_result(s_alu),
        .fwd_valid(s_fwd_valid), .fwd_address(s_fwd_address), .fwd_data(s_fwd_data),
        .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_all();
        pl_t h;
        bit  v;
        v = (mq.size() > 0);
        h = last_head;
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_alu_result", 64'(out_alu_result), 64'(h.alu));
        chk("out_data_2", 64'(out_data_2), 64'(h.d2));
        chk("out_write_address", 64'(out_write_address), 64'(h.wa));
        chk("out_fun_3", 64'(out_fun_3), 64'(h.f3));
        chk("out_mux_d_mem", 64'(out_mux_d_mem), 64'(h.mux));
        chk("out_write_reg_en", 64'(out_write_reg_en), 64'(v && h.wre));
        chk("out_d_mem_r", 64'(out_d_mem_r), 64'(v && h.r));
        chk("out_d_mem_w", 64'(out_d_mem_w), 64'(v && h.w));
        chk("fwd_valid", 64'(fwd_valid), 64'(v && h.wre && !h.mux && (h.wa != 5'd0)));
        chk("fwd_address", 64'(fwd_address), 64'(h.wa));
        chk("fwd_data", 64'(fwd_data), 64'(h.alu));
        chk("stall_count", 64'(stall_count), 64'(mcnt));
    endtask

    // Drive one cycle, advance the model across the edge, then compare.
    task automatic step(input pl_t p, input logic iv, input logic ordy, input logic fl);
        bit in_f, out_f;
        drv = p; in_valid = iv; out_ready = ordy; flush = fl;
        in_f  = iv && (mq.size() < 2);
        out_f = (mq.size() > 0) && ordy;
        if (out_f) got.push_back(out_alu_result);
        if (mq.size() > 0 && !ordy && !fl && mcnt < 65535) mcnt++;
        if (fl) mq.delete();
        else begin
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(p);
        end
        if (mq.size() > 0) last_head = mq[0];
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic pl_t mk(input logic [31:0] alu, input logic wre, input logic mux,
                               input logic [4:0] wa, input logic w);
        pl_t p;
        p = '0;
        p.alu = alu; p.wre = wre; p.mux = mux; p.wa = wa; p.w = w;
        p.d2 = ~alu; p.f3 = 3'd2;
        return p;
    endfunction

    function automatic pl_t rnd();
        pl_t p;
        p.alu = $urandom();
        p.d2  = $urandom();
        {p.mux, p.wre, p.wa, p.r, p.w, p.f3} = 12'($urandom());
        return p;
    endfunction

    initial begin
        pl_t idle;
        idle = '0;

        // Reset state
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Streaming: one-cycle latency, never FULL, no stalls
        step(mk(32'h10, 1'b1, 1'b0, 5'd3, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("stream_first", 64'(out_alu_result), 64'h10);
        step(mk(32'h20, 1'b1, 1'b0, 5'd3, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("stream_second", 64'(out_alu_result), 64'h20);
        step(mk(32'h30, 1'b1, 1'b0, 5'd3, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("stream_third", 64'(out_alu_result), 64'h30);
        chk("stream_ready", 64'(in_ready), 64'd1);
        step(idle, 1'b0, 1'b1, 1'b0);
        chk("stream_stall0", 64'(stall_count), 64'd0);

        // Back-pressure: A, B captured, C refused; 5 stalled cycles
        got.delete();
        step(mk(32'h1111, 1'b0, 1'b0, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0);
        step(mk(32'h2222, 1'b0, 1'b0, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) step(mk(32'h3333, 1'b0, 1'b0, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("bp_stall5", 64'(stall_count), 64'd5);
        chk("bp_head_A", 64'(out_alu_result), 64'h1111);
        for (int i = 0; i < 2; i++) step(mk(32'h3333, 1'b0, 1'b0, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);
        chk("bp_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp_order0", 64'(got[0]), 64'h1111);
            chk("bp_order1", 64'(got[1]), 64'h2222);
            chk("bp_order2", 64'(got[2]), 64'h3333);
        end

        // Flush in FULL with a concurrent input offer
        step(mk(32'hA1, 1'b1, 1'b0, 5'd7, 1'b1), 1'b1, 1'b0, 1'b0);
        step(mk(32'hA2, 1'b1, 1'b0, 5'd8, 1'b1), 1'b1, 1'b0, 1'b0);
        chk("fl_full", 64'(in_ready), 64'd0);
        step(mk(32'hA3, 1'b1, 1'b0, 5'd9, 1'b1), 1'b1, 1'b0, 1'b1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_d_mem_w", 64'(out_d_mem_w), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        step(idle, 1'b0, 1'b1, 1'b0);
        chk("fl_dropped", 64'(out_valid), 64'd0);

        // Forwarding
        step(mk(32'hDEAD, 1'b1, 1'b0, 5'd5, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("fwd_on", 64'(fwd_valid), 64'd1);
        chk("fwd_addr5", 64'(fwd_address), 64'd5);
        chk("fwd_dead", 64'(fwd_data), 64'hDEAD);
        step(mk(32'hDEAD, 1'b1, 1'b1, 5'd5, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("fwd_load_off", 64'(fwd_valid), 64'd0);
        step(mk(32'hDEAD, 1'b1, 1'b0, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("fwd_x0_off", 64'(fwd_valid), 64'd0);
        step(idle, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(rnd(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));

        // Reset mid-stream from FULL, asserted between edges
        step(mk(32'hB1, 1'b1, 1'b0, 5'd1, 1'b1), 1'b1, 1'b0, 1'b0);
        step(mk(32'hB2, 1'b1, 1'b0, 5'd2, 1'b1), 1'b1, 1'b0, 1'b0);
        step(mk(32'hB3, 1'b1, 1'b0, 5'd3, 1'b1), 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        mq.delete(); mcnt = 0; last_head = '0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu", 64'(out_alu_result), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        check_all();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(mk(32'hC1, 1'b1, 1'b0, 5'd4, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("post_rst_accept", 64'(out_alu_result), 64'hC1);

        // Saturation with a 4-bit counter
        chk("sat_start", 64'(s_stall_count), 64'd0);
        s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_15", 64'(s_stall_count), 64'd15);
        chk("sat_head", 64'(s_alu), 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
